// File: rtl/id_alu_issue_pkg.sv
// Shared definitions for the decode/issue stage and the EX ALU: op encoding,
// RV32I major opcodes and the registered EX bundle layout.
package id_alu_issue_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_MUL  = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SHL  = 4'd6;
    localparam logic [3:0] ALU_SHR  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;
    localparam logic [3:0] ALU_LUI  = 4'd10;
    localparam logic [3:0] ALU_BEQ  = 4'd11;
    localparam logic [3:0] ALU_BGT  = 4'd12;
    localparam logic [3:0] ALU_BLT  = 4'd13;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MULD = 7'b0000001;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        rd_we;
        logic        is_branch;
        logic        branch_inv;
        logic        is_jump;
        logic        is_load;
        logic        is_store;
        logic [2:0]  funct3;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] store_data;
        logic        illegal;
    } issue_bundle_t;

    // The ALU compares unsigned only; flipping the sign bit of both operands
    // turns an unsigned compare into a signed one.
    function automatic logic [31:0] sign_flip(input logic [31:0] v);
        return v ^ 32'h8000_0000;
    endfunction

endpackage

// File: rtl/id_alu_issue_imm_gen.sv
// RV32I immediate generator: selects and sign-extends the I/S/B/U/J immediate
// implied by the major opcode; formats without an immediate yield zero.
module rv_imm_gen
    import id_alu_issue_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm
);

    always_comb begin
        imm = '0;
        case (instr[6:0])
            OPC_OP_IMM, OPC_JALR, OPC_LOAD:
                imm = {{20{instr[31]}}, instr[31:20]};
            OPC_STORE:
                imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OPC_BRANCH:
                imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm = {instr[31:12], 12'b0};
            OPC_JAL:
                imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default:
                imm = '0;
        endcase
    end

endmodule

// File: rtl/id_alu_issue.sv
// Decode/issue stage: decodes one RV32I instruction per cycle into a registered
// EX bundle in the ALU's op encoding, with load-use stall and flush.
module id_alu_issue
    import id_alu_issue_pkg::*;
#(
    parameter logic [31:0] RESET_PC_BUNDLE = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_instr,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic        ex_load_rd_v,
    input  logic [4:0]  ex_load_rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_op,
    output logic [31:0] out_a,
    output logic [31:0] out_b,
    output logic [4:0]  out_rd,
    output logic        out_rd_we,
    output logic        out_is_branch,
    output logic        out_branch_inv,
    output logic        out_is_jump,
    output logic        out_is_load,
    output logic        out_is_store,
    output logic [2:0]  out_funct3,
    output logic [31:0] out_imm,
    output logic [31:0] out_pc,
    output logic [31:0] out_store_data,
    output logic        out_illegal
);

    logic [6:0]    opcode;
    logic [2:0]    funct3;
    logic [6:0]    funct7;
    logic [4:0]    rd;
    logic [31:0]   imm;
    issue_bundle_t dec;
    issue_bundle_t bundle;
    logic          dec_writes;
    logic          dec_illegal;
    logic          use_rs1;
    logic          use_rs2;
    logic          hazard;
    logic          stall;
    logic          accept;

    assign opcode   = in_instr[6:0];
    assign rd       = in_instr[11:7];
    assign funct3   = in_instr[14:12];
    assign funct7   = in_instr[31:25];
    assign rs1_addr = in_instr[19:15];
    assign rs2_addr = in_instr[24:20];

    rv_imm_gen u_imm_gen (
        .instr (in_instr),
        .imm   (imm)
    );

    always_comb begin
        dec            = '0;
        dec.op         = ALU_ADD;
        dec.a          = rs1_data;
        dec.b          = rs2_data;
        dec.rd         = rd;
        dec.funct3     = funct3;
        dec.imm        = imm;
        dec.pc         = in_pc;
        dec.store_data = rs2_data;
        dec_writes     = 1'b0;
        dec_illegal    = 1'b0;
        use_rs1        = 1'b0;
        use_rs2        = 1'b0;
        case (opcode)
            OPC_LUI: begin
                dec.op     = ALU_LUI;
                dec.a      = '0;
                dec.b      = imm;
                dec_writes = 1'b1;
            end
            OPC_AUIPC: begin
                dec.a      = in_pc;
                dec.b      = imm;
                dec_writes = 1'b1;
            end
            OPC_JAL: begin
                dec.a       = in_pc;
                dec.b       = 32'd4;
                dec.is_jump = 1'b1;
                dec_writes  = 1'b1;
            end
            OPC_JALR: begin
                use_rs1     = 1'b1;
                dec.a       = in_pc;
                dec.b       = 32'd4;
                dec.is_jump = 1'b1;
                dec_writes  = 1'b1;
                dec_illegal = (funct3 != 3'b000);
            end
            OPC_BRANCH: begin
                use_rs1        = 1'b1;
                use_rs2        = 1'b1;
                dec.is_branch  = 1'b1;
                dec.branch_inv = funct3[0];
                case (funct3)
                    3'b000, 3'b001: dec.op = ALU_BEQ;
                    3'b100, 3'b101: begin
                        dec.op = ALU_BLT;
                        dec.a  = sign_flip(rs1_data);
                        dec.b  = sign_flip(rs2_data);
                    end
                    3'b110, 3'b111: dec.op = ALU_BLT;
                    default:        dec_illegal = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                use_rs1     = 1'b1;
                dec.b       = imm;
                dec.is_load = 1'b1;
                dec_writes  = 1'b1;
                case (funct3)
                    3'b000, 3'b001, 3'b010, 3'b100, 3'b101: dec_illegal = 1'b0;
                    default:                                dec_illegal = 1'b1;
                endcase
            end
            OPC_STORE: begin
                use_rs1      = 1'b1;
                use_rs2      = 1'b1;
                dec.b        = imm;
                dec.is_store = 1'b1;
                dec_illegal  = funct3[2] | (funct3[1:0] == 2'b11);
            end
            OPC_OP_IMM: begin
                use_rs1    = 1'b1;
                dec.b      = imm;
                dec_writes = 1'b1;
                case (funct3)
                    3'b000: dec.op = ALU_ADD;
                    3'b010: begin
                        dec.op = ALU_SLT;
                        dec.a  = sign_flip(rs1_data);
                        dec.b  = sign_flip(imm);
                    end
                    3'b011: dec.op = ALU_SLT;
                    3'b100: dec.op = ALU_XOR;
                    3'b110: dec.op = ALU_OR;
                    3'b111: dec.op = ALU_AND;
                    3'b001: begin
                        dec.op      = ALU_SHL;
                        dec.b       = {27'b0, imm[4:0]};
                        dec_illegal = (funct7 != F7_BASE);
                    end
                    default: begin
                        dec.op      = ALU_SHR;
                        dec.b       = {27'b0, imm[4:0]};
                        dec_illegal = (funct7 != F7_BASE);
                    end
                endcase
            end
            OPC_OP: begin
                use_rs1    = 1'b1;
                use_rs2    = 1'b1;
                dec_writes = 1'b1;
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        3'b000: dec.op = ALU_ADD;
                        3'b001: begin
                            dec.op = ALU_SHL;
                            dec.b  = {27'b0, rs2_data[4:0]};
                        end
                        3'b010: begin
                            dec.op = ALU_SLT;
                            dec.a  = sign_flip(rs1_data);
                            dec.b  = sign_flip(rs2_data);
                        end
                        3'b011: dec.op = ALU_SLT;
                        3'b100: dec.op = ALU_XOR;
                        3'b101: begin
                            dec.op = ALU_SHR;
                            dec.b  = {27'b0, rs2_data[4:0]};
                        end
                        3'b110: dec.op = ALU_OR;
                        default: dec.op = ALU_AND;
                    endcase
                end else if (funct7 == F7_ALT) begin
                    dec.op      = ALU_SUB;
                    dec_illegal = (funct3 != 3'b000);
                end else if (funct7 == F7_MULD) begin
                    dec.op      = ALU_MUL;
                    dec_illegal = (funct3 != 3'b000);
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            default: dec_illegal = 1'b1;
        endcase

        // An illegal encoding travels as a harmless ADD with every side effect off.
        if (dec_illegal) begin
            dec.op         = ALU_ADD;
            dec.a          = '0;
            dec.b          = '0;
            dec.is_branch  = 1'b0;
            dec.branch_inv = 1'b0;
            dec.is_jump    = 1'b0;
            dec.is_load    = 1'b0;
            dec.is_store   = 1'b0;
        end
        dec.illegal = dec_illegal;
        dec.rd_we   = dec_writes & ~dec_illegal & (rd != 5'd0);
    end

    assign hazard = ex_load_rd_v & (ex_load_rd != 5'd0)
                  & ((use_rs1 & (ex_load_rd == rs1_addr)) | (use_rs2 & (ex_load_rd == rs2_addr)));
    assign stall    = in_valid & hazard;
    assign in_ready = flush | (~stall & (~out_valid | out_ready));
    assign accept   = in_valid & in_ready & ~flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            bundle    <= '0;
            bundle.pc <= RESET_PC_BUNDLE;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            bundle    <= dec;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign out_op         = bundle.op;
    assign out_a          = bundle.a;
    assign out_b          = bundle.b;
    assign out_rd         = bundle.rd;
    assign out_rd_we      = bundle.rd_we;
    assign out_is_branch  = bundle.is_branch;
    assign out_branch_inv = bundle.branch_inv;
    assign out_is_jump    = bundle.is_jump;
    assign out_is_load    = bundle.is_load;
    assign out_is_store   = bundle.is_store;
    assign out_funct3     = bundle.funct3;
    assign out_imm        = bundle.imm;
    assign out_pc         = bundle.pc;
    assign out_store_data = bundle.store_data;
    assign out_illegal    = bundle.illegal;

endmodule

// File: tb/tb_id_alu_issue.sv
// Bench for id_alu_issue: directed scenarios plus a randomized run checked
// against an instruction-level reference model.
module tb_id_alu_issue;

    localparam logic [31:0] RST_PC = 32'h0000_1000;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        rd_we;
        logic        is_branch;
        logic        inv;
        logic        is_jump;
        logic        is_load;
        logic        is_store;
        logic [2:0]  funct3;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] sdata;
        logic        illegal;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_pc = '0;
    logic [31:0] in_instr = '0;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic        ex_load_rd_v = 1'b0;
    logic [4:0]  ex_load_rd = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [3:0]  out_op;
    logic [31:0] out_a, out_b, out_imm, out_pc, out_store_data;
    logic [4:0]  out_rd;
    logic        out_rd_we, out_is_branch, out_branch_inv, out_is_jump;
    logic        out_is_load, out_is_store, out_illegal;
    logic [2:0]  out_funct3;
    exp_t        obs;

    int n_checks = 0;
    int n_fail   = 0;

    id_alu_issue #(.RESET_PC_BUNDLE(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .ex_load_rd_v(ex_load_rd_v), .ex_load_rd(ex_load_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
        .out_a(out_a), .out_b(out_b), .out_rd(out_rd), .out_rd_we(out_rd_we),
        .out_is_branch(out_is_branch), .out_branch_inv(out_branch_inv),
        .out_is_jump(out_is_jump), .out_is_load(out_is_load), .out_is_store(out_is_store),
        .out_funct3(out_funct3), .out_imm(out_imm), .out_pc(out_pc),
        .out_store_data(out_store_data), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    assign obs = {out_op, out_a, out_b, out_rd, out_rd_we, out_is_branch, out_branch_inv,
                  out_is_jump, out_is_load, out_is_store, out_funct3, out_imm, out_pc,
                  out_store_data, out_illegal};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Reference: RV32I semantics mapped onto the ALU op set, immediates via arithmetic shifts.
    function automatic exp_t predict(input logic [31:0] pc, input logic [31:0] ins,
                                     input logic [31:0] r1, input logic [31:0] r2);
        exp_t e;
        logic signed [31:0] s;
        logic [31:0] ii, isx, ib, iu, ij, bias;
        logic [6:0] opc, f7;
        logic [2:0] f3;
        logic legal, writes;
        s    = ins;
        opc  = ins[6:0];
        f3   = ins[14:12];
        f7   = ins[31:25];
        bias = 32'h8000_0000;
        ii   = 32'(s >>> 20);
        isx  = 32'((s >>> 25) <<< 5) | 32'(ins[11:7]);
        ib   = 32'((s >>> 31) <<< 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
        iu   = ins & 32'hFFFF_F000;
        ij   = 32'((s >>> 31) <<< 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
        e = '0;
        e.rd = ins[11:7]; e.funct3 = f3; e.pc = pc; e.sdata = r2; e.a = r1; e.b = r2;
        legal = 1'b1; writes = 1'b1;
        case (opc)
            7'b0110111: begin e.imm = iu; e.op = 4'd10; e.a = 0; e.b = iu; end
            7'b0010111: begin e.imm = iu; e.a = pc; e.b = iu; end
            7'b1101111: begin e.imm = ij; e.a = pc; e.b = 4; e.is_jump = 1; end
            7'b1100111: begin e.imm = ii; e.a = pc; e.b = 4; e.is_jump = 1; legal = (f3 == 0); end
            7'b1100011: begin
                e.imm = ib; writes = 0; e.is_branch = 1; e.inv = f3[0];
                if (f3 == 0 || f3 == 1) e.op = 4'd11;
                else if (f3 == 4 || f3 == 5) begin e.op = 4'd13; e.a = r1 + bias; e.b = r2 + bias; end
                else if (f3 == 6 || f3 == 7) e.op = 4'd13;
                else legal = 0;
            end
            7'b0000011: begin e.imm = ii; e.b = ii; e.is_load = 1; legal = f3 inside {0, 1, 2, 4, 5}; end
            7'b0100011: begin e.imm = isx; e.b = isx; e.is_store = 1; writes = 0; legal = (f3 <= 2); end
            7'b0010011: begin
                e.imm = ii; e.b = ii;
                case (f3)
                    0: e.op = 4'd0;
                    1: begin e.op = 4'd6; e.b = ii & 31; legal = (f7 == 0); end
                    2: begin e.op = 4'd8; e.a = r1 + bias; e.b = ii + bias; end
                    3: e.op = 4'd8;
                    4: e.op = 4'd5;
                    5: begin e.op = 4'd7; e.b = ii & 31; legal = (f7 == 0); end
                    6: e.op = 4'd4;
                    default: e.op = 4'd3;
                endcase
            end
            7'b0110011: begin
                if (f7 == 7'h01) begin e.op = 4'd2; legal = (f3 == 0); end
                else if (f7 == 7'h20) begin e.op = 4'd1; legal = (f3 == 0); end
                else if (f7 == 7'h00) begin
                    case (f3)
                        0: e.op = 4'd0;
                        1: begin e.op = 4'd6; e.b = r2 & 31; end
                        2: begin e.op = 4'd8; e.a = r1 + bias; e.b = r2 + bias; end
                        3: e.op = 4'd8;
                        4: e.op = 4'd5;
                        5: begin e.op = 4'd7; e.b = r2 & 31; end
                        6: e.op = 4'd4;
                        default: e.op = 4'd3;
                    endcase
                end else legal = 0;
            end
            default: legal = 0;
        endcase
        if (!legal) begin
            e.op = 0; e.a = 0; e.b = 0; e.is_branch = 0; e.inv = 0;
            e.is_jump = 0; e.is_load = 0; e.is_store = 0;
        end
        e.illegal = !legal;
        e.rd_we   = legal && writes && (e.rd != 0);
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0] opc, f7;
        case ($urandom_range(0, 9))
            0: opc = 7'b0110111;  1: opc = 7'b0010111;  2: opc = 7'b1101111;
            3: opc = 7'b1100111;  4: opc = 7'b1100011;  5: opc = 7'b0000011;
            6: opc = 7'b0100011;  7: opc = 7'b0010011;  8: opc = 7'b0110011;
            default: opc = 7'($urandom);
        endcase
        case ($urandom_range(0, 4))
            0, 1: f7 = 7'h00;
            2: f7 = 7'h20;
            3: f7 = 7'h01;
            default: f7 = 7'($urandom);
        endcase
        if ($urandom_range(0, 9) == 0) return $urandom;
        return {f7, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 3'($urandom),
                5'($urandom_range(0, 7)), opc};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({out_valid, out_pc, out_op, out_a, out_b, out_imm, out_illegal, out_rd_we} !==
            {1'b0, RST_PC, 4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: got valid=%b pc=%h op=%0d a=%h b=%h, want valid=0 pc=%h op=0 a=0 b=0",
                     out_valid, out_pc, out_op, out_a, out_b, RST_PC);
        end
        rst_n = 1'b1;
        settle();
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_addi();
        in_valid = 1; in_pc = 32'h100; in_instr = 32'h0050_0093;
        rs1_data = 0; rs2_data = 32'h1234; out_ready = 1;
        settle();
        n_checks++;
        if ({in_ready, rs1_addr, rs2_addr} !== {1'b1, 5'd0, 5'd5}) begin
            n_fail++;
            $display("FAIL addi_addr: got ready=%b rs1=%0d rs2=%0d want 1 0 5", in_ready, rs1_addr, rs2_addr);
        end
        tick();
        in_valid = 0;
        n_checks++;
        if ({out_valid, out_op, out_a, out_b, out_rd, out_rd_we, out_pc} !==
            {1'b1, 4'd0, 32'd0, 32'd5, 5'd1, 1'b1, 32'h100}) begin
            n_fail++;
            $display("FAIL addi_bundle: got v=%b op=%0d a=%h b=%h rd=%0d we=%b pc=%h want 1 0 0 5 1 1 100",
                     out_valid, out_op, out_a, out_b, out_rd, out_rd_we, out_pc);
        end
    endtask

    task automatic test_slt();
        in_valid = 1; in_instr = 32'h0020_A1B3; rs1_data = 32'hFFFF_FFFF; rs2_data = 32'd1;
        settle();
        n_checks++;
        if ({rs1_addr, rs2_addr} !== {5'd1, 5'd2}) begin
            n_fail++;
            $display("FAIL slt_addr: got rs1=%0d rs2=%0d want 1 2", rs1_addr, rs2_addr);
        end
        tick();
        n_checks++;
        if ({out_valid, out_op, out_a, out_b, out_rd, out_rd_we} !==
            {1'b1, 4'd8, 32'h7FFF_FFFF, 32'h8000_0001, 5'd3, 1'b1}) begin
            n_fail++;
            $display("FAIL slt_signed: got op=%0d a=%h b=%h rd=%0d want 8 7fffffff 80000001 3",
                     out_op, out_a, out_b, out_rd);
        end
        in_instr = 32'h0020_B1B3;
        tick();
        in_valid = 0;
        n_checks++;
        if ({out_valid, out_op, out_a, out_b} !== {1'b1, 4'd8, 32'hFFFF_FFFF, 32'd1}) begin
            n_fail++;
            $display("FAIL sltu_unsigned: got op=%0d a=%h b=%h want 8 ffffffff 00000001", out_op, out_a, out_b);
        end
    endtask

    task automatic test_branch();
        in_valid = 1; in_instr = 32'h0020_D463; rs1_data = 32'hFFFF_FFFF; rs2_data = 32'd0;
        tick();
        n_checks++;
        if ({out_op, out_branch_inv, out_is_branch, out_rd_we, out_a, out_b, out_imm} !==
            {4'd13, 1'b1, 1'b1, 1'b0, 32'h7FFF_FFFF, 32'h8000_0000, 32'd8}) begin
            n_fail++;
            $display("FAIL bge: got op=%0d inv=%b br=%b we=%b a=%h b=%h imm=%h want 13 1 1 0 7fffffff 80000000 8",
                     out_op, out_branch_inv, out_is_branch, out_rd_we, out_a, out_b, out_imm);
        end
        in_instr = 32'h0020_9463;
        tick();
        in_valid = 0;
        n_checks++;
        if ({out_op, out_branch_inv, out_is_branch, out_rd_we, out_a, out_b} !==
            {4'd11, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd0}) begin
            n_fail++;
            $display("FAIL bne: got op=%0d inv=%b br=%b we=%b a=%h b=%h want 11 1 1 0 ffffffff 0",
                     out_op, out_branch_inv, out_is_branch, out_rd_we, out_a, out_b);
        end
    endtask

    task automatic test_backpressure();
        in_valid = 1; in_instr = 32'h0050_0093; rs1_data = 0; out_ready = 1;
        tick();
        in_instr = 32'h0070_0113; out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            settle();
            n_checks++;
            if (in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_ready[%0d]: got %b want 0", i, in_ready);
            end
            tick();
            n_checks++;
            if ({out_valid, out_rd, out_b} !== {1'b1, 5'd1, 32'd5}) begin
                n_fail++;
                $display("FAIL hold_bundle[%0d]: got v=%b rd=%0d b=%h want 1 1 5", i, out_valid, out_rd, out_b);
            end
        end
        out_ready = 1;
        settle();
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL release_ready: got %b want 1", in_ready);
        end
        tick();
        in_valid = 0;
        n_checks++;
        if ({out_valid, out_rd, out_b} !== {1'b1, 5'd2, 32'd7}) begin
            n_fail++;
            $display("FAIL release_bundle: got v=%b rd=%0d b=%h want 1 2 7", out_valid, out_rd, out_b);
        end
    endtask

    task automatic test_load_use();
        out_ready = 1; ex_load_rd_v = 1; ex_load_rd = 5'd5;
        in_valid = 1; in_instr = 32'h0012_8333; rs1_data = 32'd10; rs2_data = 32'd20;
        settle();
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_ready: got %b want 0", in_ready);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_bubble: got valid=%b want 0", out_valid);
        end
        ex_load_rd_v = 0;
        settle();
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_clear_ready: got %b want 1", in_ready);
        end
        tick();
        n_checks++;
        if ({out_valid, out_rd, out_op, out_a, out_b, out_rd_we} !==
            {1'b1, 5'd6, 4'd0, 32'd10, 32'd20, 1'b1}) begin
            n_fail++;
            $display("FAIL stall_issue: got v=%b rd=%0d op=%0d a=%h b=%h we=%b want 1 6 0 a 14 1",
                     out_valid, out_rd, out_op, out_a, out_b, out_rd_we);
        end
        ex_load_rd_v = 1;
        tick();
        flush = 1;
        settle();
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_ready: got %b want 1", in_ready);
        end
        tick();
        flush = 0; in_valid = 0; ex_load_rd_v = 0;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_kill: got valid=%b want 0", out_valid);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_nothing_issued: got valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_illegal_reset();
        out_ready = 1; in_valid = 1; in_instr = 32'h4020_D1B3; rs1_data = 32'd5; rs2_data = 32'd3;
        tick();
        n_checks++;
        if ({out_valid, out_illegal, out_op, out_rd_we, out_is_load, out_is_store} !==
            {1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL sra_illegal: got v=%b ill=%b op=%0d we=%b want 1 1 0 0",
                     out_valid, out_illegal, out_op, out_rd_we);
        end
        in_instr = 32'h0050_0093; rs1_data = 0;
        tick();
        n_checks++;
        if ({out_valid, out_illegal, out_rd_we} !== {1'b1, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL after_illegal: got v=%b ill=%b we=%b want 1 0 1", out_valid, out_illegal, out_rd_we);
        end
        rst_n = 0;
        tick();
        n_checks++;
        if ({out_valid, out_pc} !== {1'b0, RST_PC}) begin
            n_fail++;
            $display("FAIL midstream_reset: got v=%b pc=%h want 0 %h", out_valid, out_pc, RST_PC);
        end
        rst_n = 1; in_valid = 0;
        tick();
    endtask

    task automatic test_random();
        exp_t mb, e;
        logic mv, exp_rdy, haz, u1, u2;
        logic [6:0] opc;
        rst_n = 0; flush = 0; in_valid = 0; ex_load_rd_v = 0;
        tick();
        rst_n = 1;
        mv = 0; mb = '0; mb.pc = RST_PC;
        for (int i = 0; i < 400; i++) begin
            in_valid     = ($urandom_range(0, 3) != 0);
            out_ready    = ($urandom_range(0, 9) < 7);
            flush        = ($urandom_range(0, 19) == 0);
            in_instr     = rand_instr();
            in_pc        = $urandom & ~32'h3;
            rs1_data     = $urandom;
            rs2_data     = $urandom;
            ex_load_rd_v = ($urandom_range(0, 2) == 0);
            ex_load_rd   = 5'($urandom_range(0, 7));
            settle();
            opc = in_instr[6:0];
            u1  = opc inside {7'b0110011, 7'b0010011, 7'b1100111, 7'b0000011, 7'b0100011, 7'b1100011};
            u2  = opc inside {7'b0110011, 7'b0100011, 7'b1100011};
            haz = in_valid && ex_load_rd_v && (ex_load_rd != 0) &&
                  ((u1 && ex_load_rd == in_instr[19:15]) || (u2 && ex_load_rd == in_instr[24:20]));
            exp_rdy = flush || (!haz && (!mv || out_ready));
            n_checks++;
            if ({in_ready, rs1_addr, rs2_addr} !== {exp_rdy, in_instr[19:15], in_instr[24:20]}) begin
                n_fail++;
                $display("FAIL rand_ready[%0d]: got ready=%b rs1=%0d rs2=%0d want %b %0d %0d (instr %h)",
                         i, in_ready, rs1_addr, rs2_addr, exp_rdy, in_instr[19:15], in_instr[24:20], in_instr);
            end
            e = predict(in_pc, in_instr, rs1_data, rs2_data);
            if (flush) mv = 0;
            else if (in_valid && exp_rdy) begin mv = 1; mb = e; end
            else if (out_ready) mv = 0;
            tick();
            n_checks++;
            if (out_valid !== mv) begin
                n_fail++;
                $display("FAIL rand_valid[%0d]: got %b want %b", i, out_valid, mv);
            end
            if (mv) begin
                n_checks++;
                if (obs !== mb) begin
                    n_fail++;
                    $display("FAIL rand_bundle[%0d]: got %h want %h", i, obs, mb);
                end
            end
        end
        in_valid = 0; flush = 0; ex_load_rd_v = 0;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_slt();
        test_branch();
        test_backpressure();
        test_load_use();
        test_illegal_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
